// File: rtl/rtc_seq_engine.sv
// Register-sequence engine for the parallel-bus RTC: walks NUM_REGS registers, one address+data bus cycle each.
// Optional read-back sweep enabled by defining RTC_SEQ_READBACK_EN.
module rtc_seq_engine #(
    parameter int NUM_REGS     = 11,
    parameter int PHASE_CYCLES = 5,
    parameter int IDX_W        = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    reg_idx,
    output logic [NUM_REGS-1:0] addr_sel,
    output logic [1:0]          data_sel,
    output logic                drive_bus,
    output logic                ctrl_sel,
    output logic                rd_capture,
    output logic                a_d,
    output logic                cs,
    output logic                rd,
    output logic                wr
);

    localparam int CNT_W = $clog2(PHASE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

`ifdef RTC_SEQ_READBACK_EN
    localparam logic READBACK = 1'b1;
`else
    localparam logic READBACK = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE,
        ADDR_SU,
        ADDR_STB,
        ADDR_HLD,
        DATA_SU,
        DATA_STB,
        DATA_HLD,
        NEXT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] phase_cnt;
    logic             mode_q;
    logic             timed;
    logic             phase_last;

    assign timed      = (state inside {ADDR_SU, ADDR_STB, ADDR_HLD, DATA_SU, DATA_STB, DATA_HLD});
    assign phase_last = (phase_cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start)      state_next = ADDR_SU;
            ADDR_SU:  if (phase_last) state_next = ADDR_STB;
            ADDR_STB: if (phase_last) state_next = ADDR_HLD;
            ADDR_HLD: if (phase_last) state_next = DATA_SU;
            DATA_SU:  if (phase_last) state_next = DATA_STB;
            DATA_STB: if (phase_last) state_next = DATA_HLD;
            DATA_HLD: if (phase_last) state_next = (reg_idx < IDX_LAST) ? NEXT : DONE;
            NEXT:                     state_next = ADDR_SU;
            DONE:                     state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // The phase counter restarts on every state change so each timed state lasts PHASE_CYCLES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            reg_idx   <= '0;
            mode_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                phase_cnt <= '0;
            end else if (timed) begin
                phase_cnt <= phase_cnt + CNT_W'(1);
            end
            if (state == IDLE && start) begin
                reg_idx <= '0;
                mode_q  <= mode & READBACK;
            end else if (state == NEXT) begin
                reg_idx <= reg_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        ctrl_sel   = busy;
        a_d        = 1'b1;
        cs         = 1'b1;
        rd         = 1'b1;
        wr         = 1'b1;
        addr_sel   = '0;
        data_sel   = 2'b00;
        drive_bus  = 1'b0;
        rd_capture = 1'b0;
        case (state)
            ADDR_SU, ADDR_STB, ADDR_HLD: begin
                cs        = 1'b0;
                a_d       = 1'b0;
                drive_bus = 1'b1;
                addr_sel  = NUM_REGS'(1) << reg_idx;
                if (state == ADDR_STB) wr = 1'b0;
            end
            DATA_SU, DATA_STB, DATA_HLD: begin
                cs        = 1'b0;
                drive_bus = ~mode_q;
                // First register takes the init constant, the last (command) register external data.
                if (!mode_q) begin
                    if (reg_idx == '0)          data_sel = 2'b01;
                    else if (reg_idx == IDX_LAST) data_sel = 2'b00;
                    else                        data_sel = 2'b10;
                end
                if (state == DATA_STB) begin
                    if (mode_q) begin
                        rd         = 1'b0;
                        rd_capture = phase_last;
                    end else begin
                        wr = 1'b0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_rtc_seq_engine.sv
// Scoreboard bench for rtc_seq_engine: per-register bus transactions and per-sweep busy counts are
// predicted at stimulus time and compared by a negedge monitor.
module tb_rtc_seq_engine;

    localparam int N = 11;
    localparam int P = 2;
    localparam int W = 4;
    localparam int SWEEP_CYCLES = N * (6 * P + 1);

`ifdef RTC_SEQ_READBACK_EN
    localparam logic RB = 1'b1;
`else
    localparam logic RB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic         busy, done, drive_bus, ctrl_sel, rd_capture, a_d, cs, rd, wr;
    logic [W-1:0] reg_idx;
    logic [N-1:0] addr_sel;
    logic [1:0]   data_sel;

    logic         s_start = 1'b0;
    logic         s_mode = 1'b0;
    logic         s_busy, s_done, s_drive_bus, s_ctrl_sel, s_rd_capture, s_a_d, s_cs, s_rd, s_wr;
    logic [0:0]   s_reg_idx;
    logic [1:0]   s_addr_sel;
    logic [1:0]   s_data_sel;

    rtc_seq_engine #(.NUM_REGS(N), .PHASE_CYCLES(P), .IDX_W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .busy(busy), .done(done), .reg_idx(reg_idx), .addr_sel(addr_sel),
        .data_sel(data_sel), .drive_bus(drive_bus), .ctrl_sel(ctrl_sel),
        .rd_capture(rd_capture), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr)
    );

    rtc_seq_engine #(.NUM_REGS(2), .PHASE_CYCLES(1), .IDX_W(1)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .mode(s_mode),
        .busy(s_busy), .done(s_done), .reg_idx(s_reg_idx), .addr_sel(s_addr_sel),
        .data_sel(s_data_sel), .drive_bus(s_drive_bus), .ctrl_sel(s_ctrl_sel),
        .rd_capture(s_rd_capture), .a_d(s_a_d), .cs(s_cs), .rd(s_rd), .wr(s_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int addr_dat;
        int dsel;
        int wr_a;
        int wr_d;
        int rd_a;
        int rd_d;
        int caps;
        int cap_pos;
        int drv_a;
        int drv_d;
    } txn_t;

    txn_t exp_q[$];
    int   sweep_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   txn_num = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic txn_t expTxn(input int i, input logic m);
        txn_t t;
        logic em;
        em        = m & RB;
        t.addr    = 1 << i;
        t.addr_dat = 0;
        t.dsel    = em ? 0 : ((i == 0) ? 1 : ((i == N - 1) ? 0 : 2));
        t.wr_a    = P;
        t.wr_d    = em ? 0 : P;
        t.rd_a    = 0;
        t.rd_d    = em ? P : 0;
        t.caps    = em ? 1 : 0;
        t.cap_pos = em ? P : 0;
        t.drv_a   = 3 * P;
        t.drv_d   = em ? 0 : 3 * P;
        return t;
    endfunction

    task automatic pushSweep(input logic m, input int nregs, input bit full);
        for (int i = 0; i < nregs; i++) exp_q.push_back(expTxn(i, m));
        if (full) sweep_q.push_back(SWEEP_CYCLES);
    endtask

    task automatic compareTxn(input txn_t o);
        txn_t e;
        string p;
        p = $sformatf("txn%0d_", txn_num);
        txn_num++;
        if (exp_q.size() == 0) begin
            checkOutput({p, "unexpected"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            checkOutput({p, "addr_sel"}, o.addr, e.addr);
            checkOutput({p, "addr_sel_in_data"}, o.addr_dat, e.addr_dat);
            checkOutput({p, "data_sel"}, o.dsel, e.dsel);
            checkOutput({p, "wr_addr_cycles"}, o.wr_a, e.wr_a);
            checkOutput({p, "wr_data_cycles"}, o.wr_d, e.wr_d);
            checkOutput({p, "rd_addr_cycles"}, o.rd_a, e.rd_a);
            checkOutput({p, "rd_data_cycles"}, o.rd_d, e.rd_d);
            checkOutput({p, "rd_capture_count"}, o.caps, e.caps);
            checkOutput({p, "rd_capture_pos"}, o.cap_pos, e.cap_pos);
            checkOutput({p, "drive_addr_cycles"}, o.drv_a, e.drv_a);
            checkOutput({p, "drive_data_cycles"}, o.drv_d, e.drv_d);
        end
    endtask

    // Monitor: accumulates one bus transaction while cs is low, scores it when cs returns high.
    txn_t obs;
    bit   in_txn = 1'b0;
    int   busy_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            obs = '{default: 0};
            in_txn = 1'b0;
            busy_cnt = 0;
        end else begin
            if (!cs) begin
                in_txn = 1'b1;
                if (!a_d) begin
                    obs.addr = obs.addr | int'(addr_sel);
                    if (!wr) obs.wr_a++;
                    if (!rd) obs.rd_a++;
                    if (drive_bus) obs.drv_a++;
                end else begin
                    obs.addr_dat = obs.addr_dat | int'(addr_sel);
                    obs.dsel = obs.dsel | int'(data_sel);
                    if (!wr) obs.wr_d++;
                    if (!rd) obs.rd_d++;
                    if (drive_bus) obs.drv_d++;
                end
                if (rd_capture) begin
                    obs.caps++;
                    obs.cap_pos = obs.rd_d;
                end
            end else if (in_txn) begin
                compareTxn(obs);
                obs = '{default: 0};
                in_txn = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                if (sweep_q.size() == 0) checkOutput("unexpected_done", 1, 0);
                else checkOutput("sweep_busy_cycles", busy_cnt, sweep_q.pop_front());
            end
            if (!busy) busy_cnt = 0;
        end
    end

    task automatic applyStimulus(input logic m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("ctrl_sel_after_start", ctrl_sel, 1);
        checkOutput("a_d_addr_su", a_d, 0);
        checkOutput("cs_addr_su", cs, 0);
        checkOutput("drive_bus_addr_su", drive_bus, 1);
        checkOutput("reg_idx_first", reg_idx, 0);
    endtask

    task automatic waitIdle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("sweep_finished_in_budget", busy, 0);
    endtask

    initial begin
        int gap;
        int k;
        int s_cnt;
        int s_dn;
        int s_addr[2];
        int s_dsel[2];

        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_reg_idx", reg_idx, 0);
        checkOutput("rst_addr_sel", addr_sel, 0);
        checkOutput("rst_data_sel", data_sel, 0);
        checkOutput("rst_drive_bus", drive_bus, 0);
        checkOutput("rst_ctrl_sel", ctrl_sel, 0);
        checkOutput("rst_rd_capture", rd_capture, 0);
        checkOutput("rst_a_d", a_d, 1);
        checkOutput("rst_cs", cs, 1);
        checkOutput("rst_rd", rd, 1);
        checkOutput("rst_wr", wr, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        $display("[TB] write sweep");
        pushSweep(1'b0, N, 1'b1);
        applyStimulus(1'b0);
        waitIdle(200);

        $display("[TB] read sweep");
        pushSweep(1'b1, N, 1'b1);
        applyStimulus(1'b1);
        waitIdle(200);

        $display("[TB] start pulses while busy and in DONE");
        pushSweep(1'b0, N, 1'b1);
        applyStimulus(1'b0);
        for (int j = 0; j < 3; j++) begin
            repeat (30) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkOutput("done_seen", done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_in_done_ignored", busy, 0);
        repeat (5) @(negedge clk);
        checkOutput("no_extra_sweep", busy, 0);

        $display("[TB] start held high");
        pushSweep(1'b0, N, 1'b1);
        pushSweep(1'b0, N, 1'b1);
        @(negedge clk);
        start = 1'b1;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkOutput("held_first_done", done, 1);
        gap = 0;
        k = 0;
        @(negedge clk);
        while (!busy && k < 10) begin
            gap++;
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("idle_gap_cycles", gap, 1);
        waitIdle(200);
        repeat (5) @(negedge clk);
        checkOutput("no_third_sweep", busy, 0);

        $display("[TB] reset mid-sweep");
        pushSweep(1'b0, 4, 1'b0);
        applyStimulus(1'b0);
        repeat (59) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_cs", cs, 1);
        checkOutput("midrst_rd", rd, 1);
        checkOutput("midrst_wr", wr, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_reg_idx", reg_idx, 0);
        checkOutput("midrst_a_d", a_d, 1);
        checkOutput("midrst_drive_bus", drive_bus, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        pushSweep(1'b0, N, 1'b1);
        applyStimulus(1'b0);
        waitIdle(200);

        $display("[TB] NUM_REGS=2 PHASE_CYCLES=1");
        s_cnt = 0;
        s_dn = 0;
        s_addr = '{0, 0};
        s_dsel = '{0, 0};
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s_busy) s_cnt++;
            if (s_done) s_dn++;
            if (!s_cs && !s_a_d) s_addr[s_reg_idx] = s_addr[s_reg_idx] | int'(s_addr_sel);
            if (!s_cs && s_a_d) s_dsel[s_reg_idx] = s_dsel[s_reg_idx] | int'(s_data_sel);
        end
        checkOutput("small_busy_cycles", s_cnt, 14);
        checkOutput("small_done_pulses", s_dn, 1);
        checkOutput("small_addr_sel_0", s_addr[0], 1);
        checkOutput("small_addr_sel_1", s_addr[1], 2);
        checkOutput("small_data_sel_0", s_dsel[0], 1);
        checkOutput("small_data_sel_1", s_dsel[1], 0);

        repeat (3) @(negedge clk);
        checkOutput("txn_queue_drained", exp_q.size(), 0);
        checkOutput("sweep_queue_drained", sweep_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
